axil_s_regfile: RTL

Parametrised AXI4-Lite slave register file: the successor to the fixed six-register control slave in front of the FFT accelerator control path. It adds:
- configurable register count;
- a per-register read-only mask;
- independent AW/W acceptance;
- optional byte strobes;
- SLVERR on out-of-range or read-only writes;
- fixed write-over-read arbitration of the shared downstream access strobe.

It sits between the host AXI-Lite interconnect and the accelerator control logic.

---
 rtl/axil_regfile_pkg.sv | 20 ++
 rtl/axil_hold_buf.sv | 31 +++
 rtl/axil_s_regfile.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/axil_regfile_pkg.sv
// Shared types and address-decode helpers for the AXI4-Lite register file.
// Provides resp_t (OKAY/SLVERR) plus ADDR_LSB and IDX_W computations.
package axil_regfile_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  // Byte-offset bits below the register index.
  function automatic int addr_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Width of the register index field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_hold_buf.sv
// One-entry valid/ready holding buffer used for the AW, W and AR channels.
// Ports: valid/ready/d load side, take empties it, full/q expose the entry.
module axil_hold_buf #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  output logic         ready,
  input  logic [W-1:0] d,
  input  logic         take,
  output logic         full,
  output logic [W-1:0] q
);

  assign ready = !full;

  // Load and take never coincide: take needs full, load needs !full.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (valid && !full) begin
      full <= 1'b1;
      q    <= d;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_s_regfile.sv
// AXI4-Lite slave register file with read-only mask, SLVERR and write priority.
// Ports: s_axil_* AXI-Lite slave, slv_reg_down/up register bus, access strobes.
// Option: define AXIL_REGFILE_WSTRB_EN to honour wstrb byte lanes.
module axil_s_regfile
  import axil_regfile_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGISTER       = 6,
  parameter logic [NUM_REGISTER-1:0] RO_MASK = {1'b1, 5'b0}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  output logic [NUM_REGISTER*C_S_AXI_DATA_WIDTH-1:0] slv_reg_down,
  input  logic [NUM_REGISTER*C_S_AXI_DATA_WIDTH-1:0] slv_reg_up,
  output logic [$clog2(NUM_REGISTER)-1:0] access_addr,
  output logic                            read_valid,
  output logic                            write_valid
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int NR  = NUM_REGISTER;
  localparam int SW  = DW / 8;
  localparam int LSB = addr_lsb(DW);
  localparam int IW  = idx_w(NR);

  logic          aw_full, w_full, ar_full;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          write_commit, read_commit;
  logic          wr_ok, rd_ok;
  logic [DW-1:0] rd_val, wr_mask;
  logic [DW-1:0] regs [NR];
  resp_t         bresp, rresp;
  logic          unused_ok;

  assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                       s_axil_awaddr, s_axil_araddr, w_strb};

  assign write_commit = aw_full && w_full && !s_axil_bvalid;
  assign read_commit  = ar_full && !s_axil_rvalid && !write_commit;

  axil_hold_buf #(.W(IW)) u_aw (
    .clk   (clk),
    .rst   (rst),
    .valid (s_axil_awvalid),
    .ready (s_axil_awready),
    .d     (s_axil_awaddr[LSB +: IW]),
    .take  (write_commit),
    .full  (aw_full),
    .q     (aw_idx)
  );

  axil_hold_buf #(.W(DW + SW)) u_w (
    .clk   (clk),
    .rst   (rst),
    .valid (s_axil_wvalid),
    .ready (s_axil_wready),
    .d     ({s_axil_wstrb, s_axil_wdata}),
    .take  (write_commit),
    .full  (w_full),
    .q     ({w_strb, w_data})
  );

  axil_hold_buf #(.W(IW)) u_ar (
    .clk   (clk),
    .rst   (rst),
    .valid (s_axil_arvalid),
    .ready (s_axil_arready),
    .d     (s_axil_araddr[LSB +: IW]),
    .take  (read_commit),
    .full  (ar_full),
    .q     (ar_idx)
  );

`ifdef AXIL_REGFILE_WSTRB_EN
  always_comb begin
    wr_mask = '0;
    for (int k = 0; k < SW; k++)
      wr_mask[k*8 +: 8] = {8{w_strb[k]}};
  end
`else
  assign wr_mask = '1;
`endif

  // Index decode by loop so out-of-range indices fall to the defaults.
  always_comb begin
    wr_ok  = 1'b0;
    rd_ok  = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NR; i++) begin
      if (aw_idx == IW'(i))
        wr_ok = !RO_MASK[i];
      if (ar_idx == IW'(i)) begin
        rd_ok  = 1'b1;
        rd_val = RO_MASK[i] ? slv_reg_up[i*DW +: DW] : regs[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bresp         <= OKAY;
      rresp         <= OKAY;
      s_axil_bvalid <= 1'b0;
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      access_addr   <= '0;
      write_valid   <= 1'b0;
      read_valid    <= 1'b0;
      for (int i = 0; i < NR; i++)
        regs[i] <= '0;
    end else begin
      write_valid <= 1'b0;
      read_valid  <= 1'b0;
      if (write_commit) begin
        s_axil_bvalid <= 1'b1;
        bresp         <= wr_ok ? OKAY : SLVERR;
        if (wr_ok) begin
          write_valid <= 1'b1;
          access_addr <= aw_idx;
        end
        for (int i = 0; i < NR; i++)
          if (wr_ok && aw_idx == IW'(i))
            regs[i] <= (regs[i] & ~wr_mask) | (w_data & wr_mask);
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
      if (read_commit) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_val;
        rresp         <= rd_ok ? OKAY : SLVERR;
        if (rd_ok) begin
          read_valid  <= 1'b1;
          access_addr <= ar_idx;
        end
      end else if (s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

  assign s_axil_bresp = bresp;
  assign s_axil_rresp = rresp;

  for (genvar i = 0; i < NR; i++) begin : g_down
    assign slv_reg_down[i*DW +: DW] = RO_MASK[i] ? '0 : regs[i];
  end

endmodule
